alu8_exec_ctrl: RTL and testbench

Sequencing controller that issues operations to alu8 and consumes its results.
- Sits on the opposite side of the ALU interface: drives A/B/op, captures result/zero/carry.
- Holds a 4x8 register file and Z/C flag registers.
- Accepts commands over a valid/ready handshake.
- Runs single-pass ALU ops and an 8-iteration shift-add multiply built from repeated ALU ADDs.

---
 rtl/alu8_exec_pkg.sv | 35 +++
 rtl/alu8_regfile.sv | 34 +++
 rtl/alu8_exec_ctrl.sv | 158 +++++++++++++++
 tb/tb_alu8_exec_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu8_exec_pkg.sv
// Shared encodings for the alu8 execution controller: command op codes,
// FSM state codes and multiply sizing. The low three bits of the ALU op
// codes match the alu8 op input directly.
package alu8_exec_pkg;

    localparam int NREG      = 4;
    localparam int DW        = 8;
    localparam int MUL_ITERS = 8;

    // Command op codes (cmd_op). 0-5 go straight to alu8, 8 is the multiply.
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_MUL = 4'd8;

    // Controller FSM states.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_MUL  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // True for ops executed as a single alu8 pass.
    function automatic logic is_alu_op(input logic [3:0] op);
        return (op <= OP_NOT);
    endfunction

    // Only the arithmetic ops update the carry flag.
    function automatic logic sets_carry(input logic [2:0] op);
        return (op == OP_ADD[2:0]) || (op == OP_SUB[2:0]);
    endfunction

endpackage

// File: rtl/alu8_regfile.sv
// 4x8 register file: one synchronous write port, one combinational operand
// read port and one combinational debug read port.
// Writes land on the clock edge; reads see the new value the next cycle.
module alu8_regfile
    import alu8_exec_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [1:0]    waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [1:0]    raddr_i,
    output logic [DW-1:0] rdata_o,
    input  logic [1:0]    dbg_sel_i,
    output logic [DW-1:0] dbg_data_o
);

    logic [DW-1:0] mem_q [NREG];

    // Register storage: cleared on reset, single write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o    = mem_q[raddr_i];
    assign dbg_data_o = mem_q[dbg_sel_i];

endmodule

// File: rtl/alu8_exec_ctrl.sv
// Command sequencer driving an external alu8: single-pass ALU ops (done at
// T+2), 8-step shift-add MUL (done at T+9), illegal ops (done+err at T+1).
// One command in flight; cmd_ready is high only in IDLE.
module alu8_exec_ctrl
    import alu8_exec_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs,
    input  logic       cmd_use_imm,
    input  logic [7:0] cmd_imm,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    input  logic       alu_zero,
    input  logic       alu_carry,
    output logic       done,
    output logic       err,
    output logic       flag_z,
    output logic       flag_c,
    input  logic [1:0] dbg_sel,
    output logic [7:0] dbg_data
);

    logic [1:0] state_q, state_d;
    logic [2:0] op_q, op_d;
    logic [1:0] rd_q, rd_d;
    logic [7:0] opb_q, opb_d;
    logic [7:0] prod_q, prod_d;
    logic [2:0] cnt_q, cnt_d;
    logic       err_q, err_d;
    logic       flag_z_q, flag_z_d;
    logic       flag_c_q, flag_c_d;

    logic       rf_we;
    logic [1:0] rf_raddr;
    logic [7:0] rf_rdata;

    // Operand A is R[rd], which cannot change until the final write of the
    // command, so it is read live in EXEC/MUL instead of being copied. That
    // leaves the single operand port free to fetch R[rs] in IDLE.
    assign rf_raddr = (state_q == ST_IDLE) ? cmd_rs : rd_q;

    alu8_regfile u_regfile (
        .clk        (clk),
        .rst_n      (rst_n),
        .we_i       (rf_we),
        .waddr_i    (rd_q),
        .wdata_i    (alu_result),
        .raddr_i    (rf_raddr),
        .rdata_o    (rf_rdata),
        .dbg_sel_i  (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    // Next-state, ALU drive and register-write decode.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        rd_d     = rd_q;
        opb_d    = opb_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        flag_z_d = flag_z_q;
        flag_c_d = flag_c_q;
        rf_we    = 1'b0;
        alu_a    = '0;
        alu_b    = '0;
        alu_op   = '0;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op[2:0];
                    rd_d   = cmd_rd;
                    opb_d  = cmd_use_imm ? cmd_imm : rf_rdata;
                    prod_d = '0;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                    if (is_alu_op(cmd_op)) begin
                        state_d = ST_EXEC;
                    end else if (cmd_op == OP_MUL) begin
                        state_d = ST_MUL;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_DONE;
                    end
                end
            end
            ST_EXEC: begin
                alu_op   = op_q;
                alu_a    = rf_rdata;
                alu_b    = opb_q;
                rf_we    = 1'b1;
                flag_z_d = alu_zero;
                if (sets_carry(op_q)) begin
                    flag_c_d = alu_carry;
                end
                state_d = ST_DONE;
            end
            ST_MUL: begin
                // Accumulate the partial product for bit cnt of operand B.
                alu_op = OP_ADD[2:0];
                alu_a  = prod_q;
                alu_b  = opb_q[cnt_q] ? 8'(rf_rdata << cnt_q) : 8'd0;
                prod_d = alu_result;
                cnt_d  = cnt_q + 3'd1;
                if (cnt_q == 3'(MUL_ITERS - 1)) begin
                    rf_we    = 1'b1;
                    flag_z_d = alu_zero;
                    flag_c_d = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            rd_q     <= '0;
            opb_q    <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
            err_q    <= 1'b0;
            flag_z_q <= 1'b0;
            flag_c_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            rd_q     <= rd_d;
            opb_q    <= opb_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            flag_z_q <= flag_z_d;
            flag_c_q <= flag_c_d;
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign err       = done & err_q;
    assign flag_z    = flag_z_q;
    assign flag_c    = flag_c_q;

endmodule

// File: tb/tb_alu8_exec_ctrl.sv
// Bench for alu8_exec_ctrl with a behavioural alu8 attached to the ALU port.
// Expected results are queued at command issue and compared on done.
module tb_alu8_exec_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_op = '0;
    logic [1:0] cmd_rd = '0;
    logic [1:0] cmd_rs = '0;
    logic       cmd_use_imm = 1'b0;
    logic [7:0] cmd_imm = '0;
    logic [7:0] alu_a, alu_b, alu_result;
    logic [2:0] alu_op;
    logic       alu_zero, alu_carry;
    logic       done, err, flag_z, flag_c;
    logic [1:0] dbg_sel = '0;
    logic [7:0] dbg_data;

    always #5 clk = ~clk;

    alu8_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_rd      (cmd_rd),
        .cmd_rs      (cmd_rs),
        .cmd_use_imm (cmd_use_imm),
        .cmd_imm     (cmd_imm),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_op      (alu_op),
        .alu_result  (alu_result),
        .alu_zero    (alu_zero),
        .alu_carry   (alu_carry),
        .done        (done),
        .err         (err),
        .flag_z      (flag_z),
        .flag_c      (flag_c),
        .dbg_sel     (dbg_sel),
        .dbg_data    (dbg_data)
    );

    // Behavioural alu8: SUB carry = 1 when no borrow.
    logic [8:0] alu_sum;
    always_comb begin
        alu_sum    = {1'b0, alu_a} + {1'b0, alu_b};
        alu_result = '0;
        alu_carry  = 1'b0;
        case (alu_op)
            3'd0: begin alu_result = alu_sum[7:0]; alu_carry = alu_sum[8]; end
            3'd1: begin alu_result = alu_a - alu_b; alu_carry = (alu_a >= alu_b); end
            3'd2: alu_result = alu_a & alu_b;
            3'd3: alu_result = alu_a | alu_b;
            3'd4: alu_result = alu_a ^ alu_b;
            3'd5: alu_result = ~alu_a;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 8'd0);
    end

    typedef struct {
        logic       err;
        logic [7:0] val;
        logic       z;
        logic       c;
        int         due;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_r [4];
    logic       m_z, m_c;
    int         cyc = 0;
    int         done_cnt = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard consumer: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            exp_t e;
            done_cnt++;
            check_eq("done_pending", sb.size(), 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check_eq("err", err, e.err);
                check_eq("rd_value", dbg_data, e.val);
                check_eq("flag_z", flag_z, e.z);
                check_eq("flag_c", flag_c, e.c);
                check_eq("done_cycle", cyc, e.due);
                check_eq("ready_in_done", cmd_ready, 0);
                check_eq("alu_drive_idle", {alu_a, alu_b, 5'd0, alu_op}, 0);
            end
        end
    end

    // Issue one command, queue its expected outcome, wait for completion.
    // cmd_valid stays high for 'hold' extra cycles after the accept.
    task automatic issue(input logic [3:0] op, input logic [1:0] rd, input logic [1:0] rs,
                         input logic ui, input logic [7:0] imm, input int hold);
        exp_t       e;
        logic [7:0] a, b, res;
        logic [8:0] s9;
        int         lat, k, rdy_hi, prod;
        k = 0;
        while (!cmd_ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        check_eq("ready_before_issue", cmd_ready, 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs = rs;
        cmd_use_imm = ui; cmd_imm = imm; dbg_sel = rd;

        a = m_r[rd];
        b = ui ? imm : m_r[rs];
        res = m_r[rd];
        e.err = 1'b0;
        lat = 2;
        case (op)
            4'd0: begin s9 = {1'b0, a} + {1'b0, b}; res = s9[7:0]; m_c = s9[8]; end
            4'd1: begin res = a - b; m_c = (a >= b); end
            4'd2: res = a & b;
            4'd3: res = a | b;
            4'd4: res = a ^ b;
            4'd5: res = ~a;
            4'd8: begin prod = int'(a) * int'(b); res = prod[7:0]; m_c = 1'b0; lat = 9; end
            default: begin e.err = 1'b1; lat = 1; end
        endcase
        if (!e.err) begin
            m_r[rd] = res;
            m_z = (res == 8'd0);
        end
        e.val = m_r[rd];
        e.z   = m_z;
        e.c   = m_c;
        e.due = cyc + lat;
        sb.push_back(e);

        rdy_hi = 0;
        @(negedge clk);
        k = 1;
        while (!done && k < 40) begin
            if (k > hold) cmd_valid = 1'b0;
            if (cmd_ready) rdy_hi++;
            @(negedge clk);
            k++;
        end
        check_eq("done_seen", done, 1);
        check_eq("ready_low_busy", rdy_hi, 0);
        cmd_valid = 1'b0;
        @(negedge clk);
        check_eq("ready_after_done", cmd_ready, 1);
    endtask

    logic [3:0] op_tab [9];

    initial begin
        int d0;
        op_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd8, 4'd6, 4'd12};
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_z = 1'b0;
        m_c = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        check_eq("rst_done", done, 0);
        check_eq("rst_err", err, 0);
        check_eq("rst_flags", {flag_z, flag_c}, 0);
        check_eq("rst_alu", {alu_a, alu_b, 5'd0, alu_op}, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_ready", cmd_ready, 1);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 check_eq("rst_reg", dbg_data, 0);
        end

        // Directed sequence.
        issue(4'd0, 2'd0, 2'd0, 1'b1, 8'h05, 0);   // R0=05
        issue(4'd1, 2'd0, 2'd0, 1'b1, 8'h05, 0);   // R0=00 Z C
        issue(4'd1, 2'd0, 2'd0, 1'b1, 8'h01, 0);   // R0=FF borrow
        issue(4'd0, 2'd1, 2'd0, 1'b1, 8'h02, 0);   // R1=02
        issue(4'd0, 2'd1, 2'd0, 1'b1, 8'hFF, 0);   // R1=01 C
        issue(4'd2, 2'd1, 2'd0, 1'b1, 8'h00, 0);   // R1=00 Z, C kept
        issue(4'd0, 2'd2, 2'd0, 1'b1, 8'h0D, 0);   // R2=0D
        issue(4'd8, 2'd2, 2'd0, 1'b1, 8'h0B, 0);   // R2=8F
        issue(4'd0, 2'd3, 2'd0, 1'b1, 8'h10, 0);   // R3=10
        issue(4'd8, 2'd3, 2'd0, 1'b1, 8'h10, 0);   // R3=00 Z
        issue(4'd6, 2'd0, 2'd0, 1'b1, 8'h33, 0);   // illegal
        issue(4'd15, 2'd2, 2'd1, 1'b0, 8'h00, 0);  // illegal
        issue(4'd8, 2'd0, 2'd2, 1'b0, 8'h00, 0);   // R0 = FF * 8F
        issue(4'd3, 2'd1, 2'd2, 1'b0, 8'h00, 0);   // OR from register
        issue(4'd4, 2'd1, 2'd1, 1'b0, 8'h00, 0);   // XOR rd==rs -> 0
        issue(4'd5, 2'd1, 2'd0, 1'b1, 8'h00, 0);   // NOT -> FF
        issue(4'd1, 2'd2, 2'd2, 1'b0, 8'h00, 0);   // SUB rd==rs -> 0
        issue(4'd0, 2'd3, 2'd0, 1'b1, 8'h01, 3);   // valid held through EXEC/DONE
        issue(4'd0, 2'd3, 2'd0, 1'b1, 8'h00, 0);   // confirms R3 incremented once

        // Random commands.
        for (int n = 0; n < 24; n++) begin
            issue(op_tab[$urandom_range(0, 8)], 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), int'($urandom_range(0, 2)));
        end

        // Reset during MUL cycle 4.
        issue(4'd0, 2'd2, 2'd0, 1'b1, 8'h07, 0);
        cmd_valid = 1'b1; cmd_op = 4'd8; cmd_rd = 2'd2; cmd_rs = 2'd0;
        cmd_use_imm = 1'b1; cmd_imm = 8'h03;
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        d0 = done_cnt;
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_z = 1'b0;
        m_c = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        check_eq("mid_rst_no_done", done_cnt - d0, 0);
        check_eq("mid_rst_ready", cmd_ready, 1);
        check_eq("mid_rst_flags", {flag_z, flag_c}, 0);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1 check_eq("mid_rst_reg", dbg_data, 0);
        end
        @(negedge clk);
        issue(4'd0, 2'd1, 2'd0, 1'b1, 8'h2A, 0);
        issue(4'd8, 2'd1, 2'd0, 1'b1, 8'h03, 0);

        repeat (3) @(negedge clk);
        check_eq("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
